// File: rtl/dcr_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcr_bank: addressed device control register bank with kernel launch FSM.   |
// | Optional irq output enabled by defining DCR_BANK_IRQ_EN.  Revision: 1.0    |
// +----------------------------------------------------------------------------+
module dcr_bank #(
   parameter int DATA_BITS = 8,
   parameter int NUM_REGS  = 6,
   parameter int ADDR_BITS = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 device_control_write_enable,
   input  logic                 device_control_read_enable,
   input  logic [ADDR_BITS-1:0] device_control_addr,
   input  logic [DATA_BITS-1:0] device_control_data,
   output logic [DATA_BITS-1:0] device_control_read_data,
   output logic                 device_control_read_valid,
   output logic [DATA_BITS-1:0] thread_count,
   output logic [DATA_BITS-1:0] base_addr,
   output logic                 kernel_start,
   input  logic                 kernel_done,
   output logic                 busy,
   output logic                 done
`ifdef DCR_BANK_IRQ_EN
   ,
   output logic                 irq
`endif
);

   localparam int C_SCR_CNT = (NUM_REGS > 4) ? NUM_REGS - 4 : 1;

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_RUNNING = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] tc_q, tc_d;
   logic [DATA_BITS-1:0] ba_q, ba_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 kstart_q, kstart_d;
   logic [DATA_BITS-1:0] rdata_q, rdata_d;
   logic                 rvalid_q;
   logic                 irq_en_q;
   logic [DATA_BITS-1:0] scratch_q [C_SCR_CNT];

   logic w_wr_tc, w_wr_ba, w_wr_ctrl, w_wr_stat, w_start, w_launch, w_err_set, w_done_set;

   assign w_wr_tc   = device_control_write_enable && (device_control_addr == ADDR_BITS'(0));
   assign w_wr_ba   = device_control_write_enable && (device_control_addr == ADDR_BITS'(1));
   assign w_wr_ctrl = device_control_write_enable && (device_control_addr == ADDR_BITS'(2));
   assign w_wr_stat = device_control_write_enable && (device_control_addr == ADDR_BITS'(3));
   assign w_start   = w_wr_ctrl && device_control_data[0];

   always_comb begin
      state_d    = state_q;
      tc_d       = tc_q;
      ba_d       = ba_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      kstart_d   = 1'b0;
      w_launch   = 1'b0;
      w_err_set  = 1'b0;
      w_done_set = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_wr_tc) tc_d = device_control_data;
            if (w_wr_ba) ba_d = device_control_data;
            if (w_start) begin
               if (tc_q != '0) w_launch  = 1'b1;
               else            w_err_set = 1'b1;
            end
            if (w_launch) begin
               state_d  = S_RUNNING;
               kstart_d = 1'b1;
               busy_d   = 1'b1;
            end
         end
         S_RUNNING: begin
            // Launch configuration is frozen while the kernel is in flight.
            w_err_set = w_wr_tc || w_wr_ba || w_start;
            if (kernel_done) begin
               w_done_set = 1'b1;
               state_d    = S_IDLE;
               busy_d     = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Hardware set takes priority over a same-cycle write-1-to-clear.
      if (w_done_set)                                done_d = 1'b1;
      else if (w_launch)                             done_d = 1'b0;
      else if (w_wr_stat && device_control_data[1])  done_d = 1'b0;

      if (w_err_set)                                 err_d = 1'b1;
      else if (w_wr_stat && device_control_data[2])  err_d = 1'b0;
   end

   // Read mux samples pre-write state, so read-during-write returns the old value.
   always_comb begin
      rdata_d = '0;
      case (device_control_addr)
         ADDR_BITS'(0): rdata_d = tc_q;
         ADDR_BITS'(1): rdata_d = ba_q;
         ADDR_BITS'(2): rdata_d[1] = irq_en_q;
         ADDR_BITS'(3): rdata_d[2:0] = {err_q, done_q, busy_q};
         default: begin
            for (int i = 0; i < NUM_REGS - 4; i++) begin
               if (32'(device_control_addr) == i + 4) rdata_d = scratch_q[i];
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         tc_q     <= '0;
         ba_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         kstart_q <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tc_q     <= tc_d;
         ba_q     <= ba_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         kstart_q <= kstart_d;
         rvalid_q <= device_control_read_enable;
         if (device_control_read_enable) rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < C_SCR_CNT; i++) scratch_q[i] <= '0;
      end else if (device_control_write_enable) begin
         for (int i = 0; i < NUM_REGS - 4; i++) begin
            if (32'(device_control_addr) == i + 4) scratch_q[i] <= device_control_data;
         end
      end
   end

`ifdef DCR_BANK_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (w_wr_ctrl) irq_en_q <= device_control_data[1];
         irq_q <= done_q && irq_en_q;
      end
   end

   assign irq = irq_q;
`else
   assign irq_en_q = 1'b0;
`endif

   assign device_control_read_data  = rdata_q;
   assign device_control_read_valid = rvalid_q;
   assign thread_count              = tc_q;
   assign base_addr                 = ba_q;
   assign kernel_start              = kstart_q;
   assign busy                      = busy_q;
   assign done                      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dcr_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dcr_bank: directed self-checking bench with read-data scoreboard.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dcr_bank;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       we = 1'b0;
   logic       re = 1'b0;
   logic [2:0] addr = '0;
   logic [7:0] wdata = '0;
   logic [7:0] read_data;
   logic       read_valid;
   logic [7:0] thread_count;
   logic [7:0] base_addr;
   logic       kernel_start;
   logic       kernel_done = 1'b0;
   logic       busy;
   logic       done;
`ifdef DCR_BANK_IRQ_EN
   logic       irq;
`endif

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   dcr_bank dut (
      .clk                         (clk),
      .reset                       (reset),
      .device_control_write_enable (we),
      .device_control_read_enable  (re),
      .device_control_addr         (addr),
      .device_control_data         (wdata),
      .device_control_read_data    (read_data),
      .device_control_read_valid   (read_valid),
      .thread_count                (thread_count),
      .base_addr                   (base_addr),
      .kernel_start                (kernel_start),
      .kernel_done                 (kernel_done),
      .busy                        (busy),
      .done                        (done)
`ifdef DCR_BANK_IRQ_EN
      ,
      .irq                         (irq)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then retire any returned read against the scoreboard.
   task automatic tick();
      logic [7:0] e;
      @(posedge clk);
      #1;
      if (read_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rvalid", 32'(read_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("rdata", 32'(read_data), 32'(e));
         end
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      we = 1'b1; addr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [7:0] exp);
      re = 1'b1; addr = a;
      exp_q.push_back(exp);
      tick();
      re = 1'b0;
      check("rvalid_missing", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_kstart", 32'(kernel_start), 0);
      check("rst_rvalid", 32'(read_valid), 0);
`ifdef DCR_BANK_IRQ_EN
      check("rst_irq", 32'(irq), 0);
`endif
      for (int a = 0; a < 8; a++) begin
         if (a != 6) rd(3'(a), 8'h00);
      end

      // Launch
      wr(3'd0, 8'h20);
      wr(3'd1, 8'h40);
      wr(3'd2, 8'h01);
      check("launch_kstart", 32'(kernel_start), 1);
      check("launch_busy", 32'(busy), 1);
      tick();
      check("kstart_one_cycle", 32'(kernel_start), 0);
      check("run_busy", 32'(busy), 1);
      check("tc", 32'(thread_count), 32'h20);
      check("ba", 32'(base_addr), 32'h40);

      // Illegal writes while running
      wr(3'd0, 8'h05);
      check("tc_held", 32'(thread_count), 32'h20);
      wr(3'd2, 8'h01);
      check("no_restart", 32'(kernel_start), 0);
      rd(3'd3, 8'h05);
      wr(3'd3, 8'h04);
      rd(3'd3, 8'h01);

      // Completion
      kernel_done = 1'b1;
      tick();
      kernel_done = 1'b0;
      check("cmpl_busy", 32'(busy), 0);
      check("cmpl_done", 32'(done), 1);
      rd(3'd3, 8'h02);

      // Zero thread count launch attempt
      wr(3'd3, 8'h02);
      wr(3'd0, 8'h00);
      wr(3'd2, 8'h01);
      check("zero_no_kstart", 32'(kernel_start), 0);
      check("zero_busy", 32'(busy), 0);
      rd(3'd3, 8'h04);

      // Scratch, out of range, CONTROL read-back
      wr(3'd5, 8'hA5);
      rd(3'd5, 8'hA5);
      wr(3'd6, 8'h77);
      rd(3'd6, 8'h00);
      rd(3'd2, 8'h00);
      wr(3'd2, 8'h02);
`ifdef DCR_BANK_IRQ_EN
      rd(3'd2, 8'h02);
      wr(3'd2, 8'h00);
`else
      rd(3'd2, 8'h00);
`endif

      // kernel_done while idle is ignored
      kernel_done = 1'b1;
      tick();
      kernel_done = 1'b0;
      check("idle_done_ignored", 32'(done), 0);

      // Read and write same address, same cycle: pre-write value
      we = 1'b1; re = 1'b1; addr = 3'd4; wdata = 8'h3C;
      exp_q.push_back(8'h00);
      tick();
      we = 1'b0; re = 1'b0;
      check("rdw_consumed", 32'(exp_q.size()), 0);
      exp_q.delete();
      rd(3'd4, 8'h3C);

      // kernel_done coincident with kernel_start
      wr(3'd3, 8'h04);
      wr(3'd0, 8'h08);
      wr(3'd2, 8'h01);
      check("fast_kstart", 32'(kernel_start), 1);
      kernel_done = 1'b1;
      tick();
      kernel_done = 1'b0;
      check("fast_busy", 32'(busy), 0);
      check("fast_done", 32'(done), 1);
      rd(3'd3, 8'h02);

      // Hardware set beats W1C
      wr(3'd2, 8'h01);
      check("relaunch_done_clr", 32'(done), 0);
      kernel_done = 1'b1; we = 1'b1; addr = 3'd3; wdata = 8'h02;
      tick();
      kernel_done = 1'b0; we = 1'b0;
      check("set_wins", 32'(done), 1);

      // Reset mid-run
      wr(3'd3, 8'h02);
      wr(3'd1, 8'h11);
      wr(3'd2, 8'h01);
      tick(); tick();
      reset = 1'b1;
      tick();
      check("rr_busy", 32'(busy), 0);
      check("rr_done", 32'(done), 0);
      check("rr_kstart", 32'(kernel_start), 0);
      check("rr_tc", 32'(thread_count), 0);
      check("rr_ba", 32'(base_addr), 0);
      reset = 1'b0;
      tick();
      check("rr_kstart2", 32'(kernel_start), 0);
      rd(3'd5, 8'h00);
      rd(3'd4, 8'h00);
      rd(3'd3, 8'h00);

`ifdef DCR_BANK_IRQ_EN
      // Interrupt generation and clear
      wr(3'd0, 8'h08);
      wr(3'd2, 8'h03);
      rd(3'd2, 8'h02);
      kernel_done = 1'b1;
      tick();
      kernel_done = 1'b0;
      check("irq_done_rise", 32'(done), 1);
      check("irq_lag", 32'(irq), 0);
      tick();
      check("irq_set", 32'(irq), 1);
      wr(3'd3, 8'h02);
      check("irq_w1c_lag", 32'(irq), 1);
      tick();
      check("irq_clr", 32'(irq), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dcr_bank.md
Name: dcr_bank

Overview:
- Parametrised device control register bank; successor to the single-register thread-count DCR.
- Holds kernel launch configuration (thread count, base address, scratch registers) in an addressed register file with read-back.
- Owns the launch handshake to the dispatcher (start pulse out, done in) and exposes sticky status.
- Sits between the host-facing control interface and the dispatcher/core array.

Parameters:
- DATA_BITS, 8, width of every register and of the data ports.
- NUM_REGS, 6, total registers. Must be >= 4; indices 4..NUM_REGS-1 are general scratch RW.
- ADDR_BITS, 3, address width. Requires 2**ADDR_BITS >= NUM_REGS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- device_control_write_enable  in  1  write strobe.
- device_control_read_enable  in  1  read strobe.
- device_control_addr  in  ADDR_BITS  register index.
- device_control_data  in  DATA_BITS  write data.
- device_control_read_data  out  DATA_BITS  registered read data.
- device_control_read_valid  out  1  high one cycle after an accepted read.
- thread_count  out  DATA_BITS  reg 0 contents.
- base_addr  out  DATA_BITS  reg 1 contents.
- kernel_start  out  1  single-cycle launch pulse to the dispatcher.
- kernel_done  in  1  dispatcher completion pulse.
- busy  out  1  kernel running.
- done  out  1  sticky completion flag (STATUS bit1).

Behaviour:
- Interface: one clock, synchronous active-high reset. On reset, all registers, read_data, read_valid, kernel_start, busy, done, error and irq are 0; the FSM goes to IDLE.
- Register map:
  - 0 THREAD_COUNT: RW.
  - 1 BASE_ADDR: RW.
  - 2 CONTROL: bit0 START is write-1-to-launch and always reads 0; bit1 IRQ_EN is RW; other bits read 0.
  - 3 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 error (W1C); other bits read 0.
  - 4..NUM_REGS-1: scratch RW.
  - Addresses >= NUM_REGS: writes ignored, reads return 0.
- Reads: read_data and read_valid update 1 cycle after read_enable. A read and a write to the same address in the same cycle returns the pre-write value.
- FSM IDLE:
  - A CONTROL write with bit0=1 and THREAD_COUNT != 0 launches the kernel.
  - Next cycle: kernel_start=1 for exactly one cycle, busy=1, done cleared, state goes to RUNNING.
  - If THREAD_COUNT == 0: no launch, error is set, state stays IDLE.
- FSM RUNNING:
  - kernel_done=1 moves the state to IDLE next cycle: busy=0, done=1.
  - Writes to THREAD_COUNT or BASE_ADDR are ignored (values held) and set error.
  - START in RUNNING is ignored and sets error.
  - Scratch and IRQ_EN writes are always allowed.
- kernel_done in IDLE is ignored.
- kernel_done may arrive in the same cycle kernel_start is high; it is honoured, so busy lasts 1 cycle.
- W1C and a same-cycle hardware set on the same bit: set wins.
- A START write that also has bit1 set updates IRQ_EN in the same cycle.
- thread_count, base_addr, busy and done are direct register outputs (no combinational path from inputs).
- Reset mid-RUNNING: return to IDLE and clear all state. No kernel_start is emitted and no done is set.

Optional Feature:
- Macro DCR_BANK_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit), registered.
  - irq = done & IRQ_EN, updating the cycle after either bit changes.
  - irq clears the cycle after done is W1C-cleared or IRQ_EN is written 0.
- Undefined:
  - No irq port.
  - CONTROL bit1 is not stored; writes are ignored and it reads 0.

Test Plan:
- Reset, then read addresses 0..5 and 7 -> each read_data=0x00 with read_valid one cycle later. Read busy=0, done=0, kernel_start=0.
- Write THREAD_COUNT=0x20 and BASE_ADDR=0x40, then CONTROL=0x01 -> kernel_start is high exactly 1 cycle later for one cycle; busy=1; thread_count=0x20 and base_addr=0x40. Pulse kernel_done -> next cycle busy=0, done=1, STATUS reads 0x02.
- While RUNNING: write THREAD_COUNT=0x05 and CONTROL=0x01 -> thread_count stays 0x20, no second kernel_start, STATUS reads 0x05. Then write STATUS=0x04 -> STATUS reads 0x01.
- THREAD_COUNT=0 and CONTROL=0x01 -> no kernel_start, busy stays 0, STATUS reads 0x04. Write scratch reg 5=0xA5, read back -> 0xA5. Write addr 6 (out of range), read addr 6 -> 0x00.
- Launch, then assert reset 2 cycles later -> next cycle busy=0, done=0, all registers 0. Separately, hold kernel_done high in the cycle the STATUS=0x02 W1C is written -> done remains 1.
- With DCR_BANK_IRQ_EN defined: write CONTROL=0x03 with THREAD_COUNT=0x08, then pulse kernel_done -> irq=1 the cycle after done rises. Write STATUS=0x02 -> irq=0 the next cycle. With the macro undefined, CONTROL reads 0x00 after writing 0x02.
